csr_access_sequencer: RTL



---
 rtl/csr_access_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/csr_access_sequencer.sv
// Atomic CSR read-modify-write sequencer: IDLE -> READ -> WRITE per access.
// Define CSR_DEBUG_PORT_EN to add the debug requester and round-robin arbiter.
module csr_access_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req_valid,
  output logic        core_req_ready,
  input  logic [1:0]  core_req_op,
  input  logic [11:0] core_req_index,
  input  logic [31:0] core_req_data,
  output logic        core_rsp_valid,
  output logic [31:0] core_rsp_data,
  output logic        core_rsp_error,
  input  logic        dbg_req_valid,
  output logic        dbg_req_ready,
  input  logic [1:0]  dbg_req_op,
  input  logic [11:0] dbg_req_index,
  input  logic [31:0] dbg_req_data,
  output logic        dbg_rsp_valid,
  output logic [31:0] dbg_rsp_data,
  output logic        dbg_rsp_error,
  output logic        read_enable_csr,
  output logic [11:0] csr_read_index,
  input  logic [31:0] csr_read_data,
  output logic        write_enable_csr,
  output logic [11:0] csr_write_index,
  output logic [31:0] csr_write_data
);

  // CSR indices, matching the values in Defines.v.
  localparam logic [11:0] ALUCSR    = 12'h7C0;
  localparam logic [11:0] MULCSR    = 12'h7C1;
  localparam logic [11:0] DIVCSR    = 12'h7C2;
  localparam logic [11:0] MCYCLE    = 12'hB00;
  localparam logic [11:0] MCYCLEH   = 12'hB80;
  localparam logic [11:0] MINSTRET  = 12'hB02;
  localparam logic [11:0] MINSTRETH = 12'hB82;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  logic [1:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [11:0] index_q, index_d;
  logic [31:0] data_q, data_d;
  logic [31:0] old_q, old_d;
  logic        dbgOwner_q, dbgOwner_d;

  logic        grantDbg;
  logic        accept;
  logic [1:0]  reqOp;
  logic [11:0] reqIndex;
  logic [31:0] reqData;
  logic        known, writable, writeReq, legal, wrLive;
  logic [31:0] newValue;
  logic        rspValid, rspError;
  logic [31:0] rspData;

`ifdef CSR_DEBUG_PORT_EN
  logic dbgFavoured_q, dbgFavoured_d;

  // Contended grants go to whoever was not served last; a lone requester always wins.
  assign grantDbg      = dbg_req_valid & (~core_req_valid | dbgFavoured_q);
  assign dbgFavoured_d = accept ? ~grantDbg : dbgFavoured_q;
  assign reqOp         = grantDbg ? dbg_req_op    : core_req_op;
  assign reqIndex      = grantDbg ? dbg_req_index : core_req_index;
  assign reqData       = grantDbg ? dbg_req_data  : core_req_data;
  assign accept        = (state_q == IDLE) & (grantDbg ? dbg_req_valid : core_req_valid);

  always_ff @(posedge clk) begin
    if (reset) dbgFavoured_q <= 1'b0;
    else       dbgFavoured_q <= dbgFavoured_d;
  end
`else
  logic unusedDbg;

  assign unusedDbg = ^{dbg_req_valid, dbg_req_op, dbg_req_index, dbg_req_data};
  assign grantDbg  = 1'b0;
  assign reqOp     = core_req_op;
  assign reqIndex  = core_req_index;
  assign reqData   = core_req_data;
  assign accept    = (state_q == IDLE) & core_req_valid;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    index_d    = index_q;
    data_d     = data_q;
    old_d      = old_q;
    dbgOwner_d = dbgOwner_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = READ;
          op_d       = reqOp;
          index_d    = reqIndex;
          data_d     = reqData;
          dbgOwner_d = grantDbg;
        end
      end
      READ: begin
        old_d   = csr_read_data;
        state_d = WRITE;
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_RD;
      index_q    <= '0;
      data_q     <= '0;
      old_q      <= '0;
      dbgOwner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      index_q    <= index_d;
      data_q     <= data_d;
      old_q      <= old_d;
      dbgOwner_q <= dbgOwner_d;
    end
  end

  always_comb begin
    known    = 1'b0;
    writable = 1'b0;
    case (index_q)
      ALUCSR, MULCSR, DIVCSR: begin
        known    = 1'b1;
        writable = 1'b1;
      end
      MCYCLE, MCYCLEH, MINSTRET, MINSTRETH: known = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_RW:   newValue = data_q;
      OP_RS:   newValue = old_q | data_q;
      OP_RC:   newValue = old_q & ~data_q;
      default: newValue = old_q;
    endcase
  end

  // A reset arriving mid-WRITE kills both the commit and the response.
  assign writeReq = (op_q == OP_RW) | (op_q[1] & (data_q != 32'd0));
  assign legal    = known & (~writeReq | writable);
  assign wrLive   = (state_q == WRITE) & ~reset;

  assign read_enable_csr  = (state_q == READ);
  assign csr_read_index   = (state_q == READ)  ? index_q  : 12'd0;
  assign write_enable_csr = wrLive & writeReq & legal;
  assign csr_write_index  = (state_q == WRITE) ? index_q  : 12'd0;
  assign csr_write_data   = (state_q == WRITE) ? newValue : 32'd0;

  assign rspValid = wrLive;
  assign rspError = wrLive & ~legal;
  assign rspData  = (wrLive & legal) ? old_q : 32'd0;

  assign core_req_ready = (state_q == IDLE) & ~grantDbg;
  assign core_rsp_valid = rspValid & ~dbgOwner_q;
  assign core_rsp_error = rspError & ~dbgOwner_q;
  assign core_rsp_data  = dbgOwner_q ? 32'd0 : rspData;

`ifdef CSR_DEBUG_PORT_EN
  assign dbg_req_ready = (state_q == IDLE) & grantDbg;
  assign dbg_rsp_valid = rspValid & dbgOwner_q;
  assign dbg_rsp_error = rspError & dbgOwner_q;
  assign dbg_rsp_data  = dbgOwner_q ? rspData : 32'd0;
`else
  assign dbg_req_ready = 1'b0;
  assign dbg_rsp_valid = 1'b0;
  assign dbg_rsp_error = 1'b0;
  assign dbg_rsp_data  = 32'd0;
`endif

endmodule
